// File: rtl/bsg_zynq_pl_to_ps_packet_arbiter.sv
// bsg_zynq_pl_to_ps_packet_arbiter: round-robin, packet-locked arbiter feeding the PL-to-PS FIFO
module bsg_zynq_pl_to_ps_packet_arbiter #(
  parameter int num_req_p = 4,
  parameter int data_width_p = 32,
  parameter int count_width_p = 16,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [num_req_p-1:0] req_v_i,
  input  logic [num_req_p-1:0][data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0] req_last_i,
  output logic [num_req_p-1:0] req_yumi_o,
  output logic [data_width_p-1:0] fifo_data_o,
  output logic fifo_v_o,
  input  logic fifo_ready_i,
  output logic busy_o,
  output logic [id_width_lp-1:0] grant_id_o,
  output logic [num_req_p-1:0][count_width_p-1:0] pkt_count_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0] state_q, state_d;
  logic [id_width_lp-1:0] grant_q, grant_d, last_grant_q, last_grant_d, rr_id, cand;
  logic [num_req_p-1:0][count_width_p-1:0] pkt_count_q, pkt_count_d;
  logic xfer, pkt_end;
  // descending scan so the nearest index after last_grant_q wins
  always_comb begin
    rr_id = grant_q;
    cand = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      cand = id_width_lp'((int'(last_grant_q) + k) % num_req_p);
      if (req_v_i[cand]) rr_id = cand;
    end
  end
  assign busy_o = state_q == LOCK;
  assign grant_id_o = grant_q;
  assign fifo_v_o = busy_o & req_v_i[grant_q] & ~reset_i;
  assign fifo_data_o = busy_o ? req_data_i[grant_q] : '0;
  assign xfer = fifo_v_o & fifo_ready_i;
  assign pkt_end = xfer & req_last_i[grant_q];
  assign req_yumi_o = num_req_p'(xfer) << grant_q;
  assign pkt_count_o = pkt_count_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d = pkt_count_q;
    if (state_q == IDLE && |req_v_i) begin
      state_d = LOCK;
      grant_d = rr_id;
    end
    if (pkt_end) begin
      pkt_count_d[grant_q] = pkt_count_q[grant_q] + count_width_p'(1);
      last_grant_d = grant_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_grant_q <= id_width_lp'(num_req_p - 1);
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q <= pkt_count_d;
    end
  end
endmodule
